b_ram_rd_stream: RTL
====================

// Module: b_ram_rd_stream
// PURPOSE
//  Port sequencer for the single-port b_ram message store (1-cycle registered read latency).
//  Streams a run of consecutive words out to the BP update datapath over valid/ready.
//  Arbitrates the datapath's write-back traffic onto the same RAM port.
//  Absorbs read latency and downstream backpressure with a small output FIFO.
// PARAMETERS
//  WIDTH       64   RAM word width
//  DEPTH       512  RAM words
//  ADDR_WIDTH  9    RAM address width, DEPTH == 2**ADDR_WIDTH
//  FIFO_DEPTH  4    output buffer entries, >=2, power of 2
// PORTS
//  clk        in   1             clock, all state on posedge
//  rst        in   1             asynchronous, active-high reset
//  start      in   1             begin a run; sampled only in IDLE
//  base_addr  in   ADDR_WIDTH    first word address of run
//  len        in   ADDR_WIDTH+1  words in run, 0..DEPTH
//  busy       out  1             high from accepted start until done
//  done       out  1             1-cycle pulse after last word handed off
//  ram_addr   out  ADDR_WIDTH    to b_ram addr
//  ram_wr_en  out  1             to b_ram wr_en
//  ram_d_in   out  WIDTH         to b_ram d_in
//  ram_d_out  in   WIDTH         from b_ram d_out, valid 1 cycle after read issue
//  wb_valid   in   1             write-back request
//  wb_addr    in   ADDR_WIDTH    write-back address
//  wb_data    in   WIDTH         write-back data
//  wb_ready   out  1             write accepted this cycle; constant 1
//  out_valid  out  1             stream word valid
//  out_data   out  WIDTH         stream word
//  out_last   out  1             marks final word of run
//  out_ready  in   1             downstream accept
// BEHAVIOUR
//  Reset: state IDLE; busy, done, out_valid, out_last, ram_wr_en = 0; ram_addr, ram_d_in = 0; FIFO empty.
//  Reset mid-run: run aborts; FIFO contents and in-flight read are discarded; no done pulse.
//  FSM states:
//   IDLE  -> RUN on start && len != 0: latch rd_ptr = base_addr, remain = len.
//   IDLE, start && len == 0: done pulses next cycle; FSM stays IDLE; busy stays 0.
//   RUN   -> DRAIN when last read issued (remain reaches 0).
//   DRAIN -> IDLE when FIFO empty and no read in flight; done pulses that cycle; busy drops.
//  Port use, decided combinationally each cycle and registered onto ram_* outputs:
//   1) wb_valid: write cycle. ram_wr_en=1, ram_addr=wb_addr, ram_d_in=wb_data. Writes always win.
//   2) Else read issue if RUN && remain!=0 && (fifo_count + inflight) < FIFO_DEPTH.
//      Read issue: ram_wr_en=0, ram_addr=rd_ptr; rd_ptr++ wraps mod DEPTH; remain--.
//   3) Else idle: ram_wr_en=0, ram_addr holds.
//  Read latency (issue reg -> RAM reg): the issue registers ram_addr at edge N; b_ram registers
//   d_out at edge N+1; the word is pushed into the FIFO at edge N+2.
//   inflight is a 2-stage valid pipe tracking this.
//   Word appears at out_data 3 cycles after the request cycle when the FIFO is empty (min latency 3).
//  Credit: the (fifo_count + inflight) check guarantees the FIFO never overflows; no push is ever dropped.
//  Output handshake:
//   transfer when out_valid && out_ready.
//   out_valid = FIFO not empty; out_data/out_last = FIFO head, stable while out_valid && !out_ready.
//   Push and pop may happen in the same cycle.
//  out_last tagged at issue time on the read whose remain was 1; travels with data.
//  Hazard: a write-back to an address whose read is already issued returns pre-write data (read-first RAM).
//   Ordering between write-backs and reads is the caller's responsibility.
//  start while busy is ignored. wb_* is honoured in every state, including IDLE.
//  Full throughput: 1 word/cycle with out_ready=1 and no write-backs.
// TESTING
//  1) base=0x010, len=4, out_ready=1, no wb:
//     words of addr 0x010..0x013 in order; out_last on 4th; done 1 cycle after last transfer; busy high throughout.
//  2) base=0x1FE, len=4: addresses 0x1FE,0x1FF,0x000,0x001 (wrap); data matches preload.
//  3) len=8, out_ready low 10 cycles then high:
//     at most FIFO_DEPTH reads issued while stalled; no loss or duplicates; order preserved.
//  4) Run len=16 with wb_valid asserted every 3rd cycle to addr 0x100:
//     all 16 words delivered unchanged; RAM[0x100] holds last wb_data; wb_ready always 1.
//  5) start with len=0: done pulses once, busy never rises, out_valid stays 0.
//  6) Assert rst mid-run with 2 words buffered:
//     out_valid=0 immediately; busy=0; no done; a new start afterwards runs cleanly.

Source files
------------

// File: rtl/b_ram_rd_stream.sv
// rtl/b_ram_rd_stream.sv - single-port b_ram sequencer: streams a run of words out over valid/ready,
// gives write-back traffic priority on the port, and buffers read latency in a small FIFO.
module b_ram_rd_stream #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_wr_en_o,
    output logic [WIDTH-1:0]      ram_d_in_o,
    input  logic [WIDTH-1:0]      ram_d_out_i,
    input  logic                  wb_valid_i,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WIDTH-1:0]      wb_data_i,
    output logic                  wb_ready_o,
    output logic                  out_valid_o,
    output logic [WIDTH-1:0]      out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW:0]           FIFO_CAP = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   remain_q, remain_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_wr_en_q, ram_wr_en_d;
    logic [WIDTH-1:0]      ram_d_in_q, ram_d_in_d;
    logic                  zero_done_q, zero_done_d;
    logic                  inf0_q, inf1_q, last0_q, last1_q;
    logic                  issue, credit_ok, drain_done, push, pop;
    logic [CW:0]           occupancy;

    logic [WIDTH:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;

    // Words already issued but not yet in the FIFO still hold a slot, so the FIFO can never overflow.
    assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inf0_q} + {{CW{1'b0}}, inf1_q};
    assign credit_ok  = occupancy < FIFO_CAP;
    assign drain_done = (state_q == S_DRAIN) && (count_q == '0) && !inf0_q && !inf1_q;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remain_d    = remain_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_en_d = 1'b0;
        ram_d_in_d  = ram_d_in_q;
        zero_done_d = 1'b0;
        issue       = 1'b0;

        if (wb_valid_i) begin
            ram_wr_en_d = 1'b1;
            ram_addr_d  = wb_addr_i;
            ram_d_in_d  = wb_data_i;
        end else if (state_q == S_RUN && remain_q != '0 && credit_ok) begin
            issue      = 1'b1;
            ram_addr_d = rd_ptr_q;
            rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            remain_d   = remain_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d  = S_RUN;
                        rd_ptr_d = base_addr_i;
                        remain_d = len_i;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue && remain_q == REM_ONE) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            remain_q    <= '0;
            ram_addr_q  <= '0;
            ram_wr_en_q <= 1'b0;
            ram_d_in_q  <= '0;
            zero_done_q <= 1'b0;
            inf0_q      <= 1'b0;
            inf1_q      <= 1'b0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            remain_q    <= remain_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_en_q <= ram_wr_en_d;
            ram_d_in_q  <= ram_d_in_d;
            zero_done_q <= zero_done_d;
            inf0_q      <= issue;
            inf1_q      <= inf0_q;
            last0_q     <= issue && (remain_q == REM_ONE);
            last1_q     <= last0_q;
        end
    end

    // inf1_q marks the cycle in which the RAM's registered d_out holds the issued word.
    assign push = inf1_q;
    assign pop  = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr_q] <= {last1_q, ram_d_out_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = fifo_mem[rptr_q][WIDTH-1:0];
    assign out_last_o  = out_valid_o && fifo_mem[rptr_q][WIDTH];
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = zero_done_q || drain_done;
    assign wb_ready_o  = 1'b1;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wr_en_o = ram_wr_en_q;
    assign ram_d_in_o  = ram_d_in_q;
endmodule
